// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative Booth radix-4 multiplier and restoring divider with valid/ready handshake
module muldiv_unit #(
  parameter int XLEN = 64,
  parameter bit WORD_EN = 1'b1,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic             in_word,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag
);
  localparam int M = XLEN + 2;
  localparam int CW = $clog2(XLEN + 1);
  localparam bit WOK = WORD_EN && XLEN == 64;
  localparam int SH = WOK ? XLEN - 32 : 0;
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state;
  logic [2:0] op;
  logic word, qn, rn, ext;
  logic [CW-1:0] cnt;
  logic [M-1:0] mx, lo, lo_n;
  logic [M+1:0] acc, acc_n, xe, pp, sum;
  logic signed [2*M+1:0] sh;
  logic [XLEN-1:0] q, r, d, q_n, r_n, res_raw;
  logic [XLEN:0] rs;
  logic [2:0] trip;
  logic ge;
  logic word_i, sa_i, sb_i, a_neg, b_neg, dz, ovf;
  logic [XLEN-1:0] a_e, b_e, a_abs, b_abs, spec_raw;
  function automatic logic [XLEN-1:0] ext32(input logic [XLEN-1:0] v, input logic s);
    logic signed [XLEN-1:0] t;
    t = v << SH;
    t = t >>> SH;
    return s ? t : (v << SH) >> SH;
  endfunction
  always_comb begin
    word_i = WOK && in_word && (in_op == 3'd0 || in_op[2]);
    sa_i = in_op[2] ? !in_op[0] : in_op != 3'd3;
    sb_i = in_op[2] ? !in_op[0] : !in_op[1];
    a_e = word_i ? ext32(in_a, sa_i) : in_a;
    b_e = word_i ? ext32(in_b, sb_i) : in_b;
    a_neg = sa_i && a_e[XLEN-1];
    b_neg = sb_i && b_e[XLEN-1];
    a_abs = a_neg ? -a_e : a_e;
    b_abs = b_neg ? -b_e : b_e;
    dz = b_e == '0;
    ovf = !in_op[0] && ((word_i ? in_a << SH : in_a) == MIN) && b_e == '1;
    spec_raw = dz ? (in_op[1] ? a_e : '1) : (in_op[1] ? '0 : a_e);
  end
  always_comb begin
    trip = {lo[1:0], ext};
    xe = {{2{mx[M-1]}}, mx};
    pp = trip == 3'b011 ? xe << 1 : trip == 3'b100 ? -(xe << 1) :
         (trip == 3'b001 || trip == 3'b010) ? xe : (trip == 3'b101 || trip == 3'b110) ? -xe : '0;
    sum = acc + pp;
    sh = {sum, lo};
    sh = sh >>> 2;
    acc_n = sh[2*M+1:M];
    lo_n = sh[M-1:0];
    rs = {r, q[XLEN-1]};
    ge = rs >= {1'b0, d};
    r_n = ge ? XLEN'(rs - {1'b0, d}) : rs[XLEN-1:0];
    q_n = {q[XLEN-2:0], ge};
    res_raw = op[2] ? (op[1] ? (rn ? -r_n : r_n) : (qn ? -q_n : q_n)) :
              op == 3'd0 ? (word ? lo_n[XLEN-1:0] >> SH : lo_n[XLEN-1:0]) :
              {acc_n[XLEN-3:0], lo_n[XLEN+1:XLEN]};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      in_ready <= 1'b1;
      out_valid <= 1'b0;
      out_result <= '0;
      out_tag <= '0;
      cnt <= '0;
      op <= '0;
      word <= 1'b0;
      qn <= 1'b0;
      rn <= 1'b0;
      ext <= 1'b0;
      mx <= '0;
      lo <= '0;
      acc <= '0;
      q <= '0;
      r <= '0;
      d <= '0;
    end else if (flush) begin
      state <= IDLE;
      in_ready <= 1'b1;
      out_valid <= 1'b0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          op <= in_op;
          word <= word_i;
          qn <= a_neg ^ b_neg;
          rn <= a_neg;
          mx <= {{2{a_neg}}, a_e};
          lo <= {{2{b_neg}}, b_e};
          acc <= '0;
          ext <= 1'b0;
          q <= word_i ? a_abs << SH : a_abs;
          r <= '0;
          d <= b_abs;
          out_tag <= in_tag;
          in_ready <= 1'b0;
          if (in_op[2] && (dz || ovf)) begin
            out_result <= word_i ? ext32(spec_raw, 1'b1) : spec_raw;
            out_valid <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= CW'(in_op[2] ? (word_i ? 32 : XLEN) : (word_i ? 17 : XLEN / 2 + 1));
            state <= CALC;
          end
        end
        CALC: begin
          cnt <= cnt - 1'b1;
          acc <= acc_n;
          lo <= lo_n;
          ext <= lo[1];
          q <= q_n;
          r <= r_n;
          if (cnt == CW'(1)) begin
            out_result <= word ? ext32(res_raw, 1'b1) : res_raw;
            out_valid <= 1'b1;
            state <= DONE;
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised iterative multiply/divide unit; successor to the ALU's embedded mul/div state machine.
- Standalone execute-stage functional unit with a valid/ready handshake on both sides, a pass-through tag, and flush.
- Booth radix-4 multiply, radix-2 restoring divide, 32-bit word-mode early termination.
- Divide-by-zero and signed overflow complete in one cycle.

Parameters:
- XLEN, 64, operand/result width; must be even and >= 8.
- WORD_EN, 1, enables word (32-bit) mode; legal only when XLEN == 64, otherwise the word input is ignored.
- TAG_W, 5, width of the opaque tag carried from request to response.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  abort any in-flight operation
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept a request
- in_op  in  3  0 mul, 1 mulh, 2 mulhsu, 3 mulhu, 4 div, 5 divu, 6 rem, 7 remu
- in_word  in  1  32-bit (W) variant
- in_a  in  XLEN  operand A / dividend
- in_b  in  XLEN  operand B / divisor
- in_tag  in  TAG_W  request tag
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_result  out  XLEN  result
- out_tag  out  TAG_W  tag of the completed request

Behaviour:
- Single clock domain. Reset is synchronous and active-high.

State machine and handshake:
- States are IDLE, CALC, DONE.
- Reset state is IDLE. Reset values: in_ready=1, out_valid=0, out_result=0, out_tag=0, counter=0.
- IDLE:
  - in_ready=1.
  - On in_valid && !flush, latch op, word, a, b, tag. Go to CALC, or to DONE directly for special cases.
  - Operand changes after accept are ignored.
- CALC:
  - in_ready=0. One iteration per cycle.
  - After the last iteration, write out_result and go to DONE.
- DONE:
  - out_valid=1; out_result and out_tag held stable.
  - On out_ready, go to IDLE the next cycle.
  - in_ready=0 in DONE; there is no same-cycle accept.
- Flush in any state: go to IDLE next cycle, out_valid=0, the result is discarded.
- Flush with in_valid in IDLE: flush wins and the request is not accepted.
- Reset mid-operation behaves the same as flush and also clears the registers.

Latency (accept edge = T; out_valid first high in cycle T+1+N):
- mul family, full width: N = XLEN/2 + 1 (33 at XLEN=64).
- mul family, word: N = 17.
- div family, full width: N = XLEN.
- div family, word: N = 32.
- Special cases: N = 0 (DONE in cycle T+1).

Multiply (Booth radix-4):
- Operands are extended to XLEN+2 bits: signed for mul/mulh, A signed and B unsigned for mulhsu, both unsigned for mulhu.
- Each cycle: add one of {0, ±X, ±2X} per the Booth triplet, then arithmetic-shift the {acc, Y} pair right by 2.
- mul returns product[XLEN-1:0]; mulh* return product[2*XLEN-1:XLEN].
- Word mode applies to mul only (mulw): operands[31:0], result = sext(product[31:0]).
- Word with mulh/mulhsu/mulhu: the word flag is ignored.

Divide (restoring):
- div/rem operate on absolute values.
- Quotient sign = sign(A) XOR sign(B); remainder sign = sign(A).
- Word mode uses operands[31:0]. Every word result, including divuw/remuw, is sext(result[31:0]).
- Divide by zero (B==0 at the effective width):
  - div/divu → all ones (sign-extended in word mode).
  - rem/remu → A (sign-extended in word mode).
- Signed overflow (A = most negative, B = -1, div/rem only): quotient = A, remainder = 0.

Test Plan:
- mul, XLEN=64: a=3, b=0xFFFF_FFFF_FFFF_FFFB (-5) → out_result=0xFFFF_FFFF_FFFF_FFF1, out_valid first at T+34, out_tag echoed.
- mulhu: a=b=0xFFFF_FFFF_FFFF_FFFF → 0xFFFF_FFFF_FFFF_FFFE. mulhsu: a=-1, b=2 → 0xFFFF_FFFF_FFFF_FFFF.
- div a=7, b=0 → 0xFFFF_FFFF_FFFF_FFFF at T+1. rem a=7, b=0 → 7 at T+1.
- div a=0x8000_0000_0000_0000, b=-1 → 0x8000_0000_0000_0000 at T+1. rem with the same operands → 0.
- Word mode:
  - divw a=-7, b=2 → 0xFFFF_FFFF_FFFF_FFFD at T+33.
  - remw → 0xFFFF_FFFF_FFFF_FFFF.
  - divuw a=0x1_8000_0000, b=1 → 0xFFFF_FFFF_8000_0000.
- Back-pressure and flush:
  - Hold out_ready=0 for 5 cycles in DONE → out_result and out_tag stable, in_ready=0.
  - Assert flush at CALC cycle 10 → out_valid stays 0 and in_ready=1 next cycle; a new mul 6*7 then returns 42.
